// File: rtl/ibex_pkg.sv
// Shared types and helpers for the wide instruction fetch path.
package ibex_pkg;

  typedef struct packed {
    logic [15:0] data;
    logic        err;
  } fetch_hw_t;

  localparam int unsigned FETCH_W_DEFAULT = 32;

  function automatic int unsigned fetch_hw_per_beat(int unsigned fetch_w);
    return fetch_w / 16;
  endfunction

  localparam int unsigned FETCH_HW_PER_BEAT = fetch_hw_per_beat(FETCH_W_DEFAULT);

endpackage

// File: rtl/ibex_fetch_aligner.sv
// Halfword aligner: picks the two halfwords at the PC offset and decides
// compressed/straddle, validity and error attribution.
module ibex_fetch_aligner import ibex_pkg::*; #(
  parameter int unsigned FETCH_W = 32
) (
  input  logic [$clog2(FETCH_W/16)-1:0] off,
  input  logic [FETCH_W-1:0]            src0_data,
  input  logic                          src0_err,
  input  logic                          src0_valid,
  input  logic [15:0]                   src1_data,
  input  logic                          src1_err,
  input  logic                          src1_valid,
  output fetch_hw_t                     hw0,
  output fetch_hw_t                     hw1,
  output logic                          is_c,
  output logic                          straddle,
  output logic                          out_valid,
  output logic                          out_err,
  output logic                          err_plus2
);

  localparam int unsigned H     = fetch_hw_per_beat(FETCH_W);
  localparam int unsigned OFF_W = $clog2(H);

  fetch_hw_t src0_hw [H];
  fetch_hw_t src1_hw0;
  logic      last_hw;

  for (genvar i = 0; i < H; i++) begin : g_split
    assign src0_hw[i] = {src0_data[16*i +: 16], src0_err};
  end

  assign src1_hw0 = {src1_data, src1_err};
  assign last_hw  = &off;

  assign hw0 = src0_hw[off];
  assign hw1 = last_hw ? src1_hw0 : src0_hw[off + OFF_W'(1)];

  // An errored first halfword is treated as a 4-byte instruction.
  assign is_c      = (hw0.data[1:0] != 2'b11) & ~hw0.err;
  assign straddle  = ~is_c & last_hw;
  assign out_valid = straddle ? src1_valid : src0_valid;
  assign out_err   = hw0.err | (~is_c & hw1.err);
  assign err_plus2 = straddle & hw1.err & ~hw0.err;

endmodule

// File: rtl/ibex_fetch_fifo_wide.sv
// Instruction fetch FIFO with FETCH_W-wide entries, bypass path and a
// halfword-granular aligner presenting one instruction per handshake.
module ibex_fetch_fifo_wide import ibex_pkg::*; #(
  parameter int unsigned NUM_REQS = 2,
  parameter int unsigned FETCH_W  = 32,
  parameter bit          ResetAll = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          clear_i,
  output logic [NUM_REQS-1:0]           busy_o,
  output logic [$clog2(NUM_REQS+2)-1:0] level_o,
  input  logic                          in_valid_i,
  input  logic [31:0]                   in_addr_i,
  input  logic [FETCH_W-1:0]            in_rdata_i,
  input  logic                          in_err_i,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  output logic [31:0]                   out_addr_o,
  output logic [31:0]                   out_rdata_o,
  output logic                          out_err_o,
  output logic                          out_err_plus2_o
);

  localparam int unsigned DEPTH = NUM_REQS + 1;
  localparam int unsigned H     = fetch_hw_per_beat(FETCH_W);
  localparam int unsigned OFF_W = $clog2(H);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  if (FETCH_W != 32 && FETCH_W != 64) begin : g_bad_fetch_w
    $error("ibex_fetch_fifo_wide: FETCH_W must be 32 or 64");
  end

  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [DEPTH-1:0]   err_q, err_d;
  logic [FETCH_W-1:0] data_q [DEPTH];
  logic [FETCH_W-1:0] data_d [DEPTH];
  logic [31:1]        pc_q, pc_next;
  logic [OFF_W-1:0]   off;
  logic [OFF_W:0]     off_end;

  logic [FETCH_W-1:0] src0_data;
  logic [15:0]        src1_data;
  logic               src0_err, src0_valid, src1_err, src1_valid;
  fetch_hw_t          hw0, hw1;
  logic               is_c, straddle;
  logic               handshake, pop;
  logic [DEPTH:0]     free_lo;
  logic [DEPTH-1:0]   push_sel;

  assign off = pc_q[OFF_W:1];

  // Empty slots fall through to the incoming response with zero latency.
  assign src0_data  = valid_q[0] ? data_q[0] : in_rdata_i;
  assign src0_err   = valid_q[0] ? err_q[0]  : in_err_i;
  assign src0_valid = valid_q[0] | in_valid_i;
  assign src1_data  = valid_q[1] ? data_q[1][15:0] : in_rdata_i[15:0];
  assign src1_err   = valid_q[1] ? err_q[1]        : in_err_i;
  assign src1_valid = valid_q[1] | (valid_q[0] & in_valid_i);

  ibex_fetch_aligner #(
    .FETCH_W (FETCH_W)
  ) u_aligner (
    .off        (off),
    .src0_data  (src0_data),
    .src0_err   (src0_err),
    .src0_valid (src0_valid),
    .src1_data  (src1_data),
    .src1_err   (src1_err),
    .src1_valid (src1_valid),
    .hw0        (hw0),
    .hw1        (hw1),
    .is_c       (is_c),
    .straddle   (straddle),
    .out_valid  (out_valid_o),
    .out_err    (out_err_o),
    .err_plus2  (out_err_plus2_o)
  );

  assign out_rdata_o = {hw1.data, hw0.data};
  assign out_addr_o  = {pc_q, 1'b0};

  assign handshake = out_valid_o & out_ready_i & ~clear_i;
  assign off_end   = {1'b0, off} + (is_c ? (OFF_W+1)'(1) : (OFF_W+1)'(2));
  assign pop       = handshake & (off_end >= (OFF_W+1)'(H));
  assign pc_next   = pc_q + (is_c ? 31'd1 : 31'd2);

  // One-hot of the lowest free slot; a pop moves the target down by one,
  // so a bypassed beat that is fully consumed is never stored.
  assign free_lo  = {valid_q, 1'b1} & ~{1'b0, valid_q};
  assign push_sel = pop ? free_lo[DEPTH:1] : free_lo[DEPTH-1:0];

  always_comb begin
    valid_d = valid_q;
    err_d   = err_q;
    for (int i = 0; i < DEPTH; i++) data_d[i] = data_q[i];
    if (pop) begin
      valid_d = valid_q >> 1;
      err_d   = err_q >> 1;
      for (int i = 0; i < DEPTH - 1; i++) data_d[i] = data_q[i+1];
    end
    if (in_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push_sel[i]) begin
          valid_d[i] = 1'b1;
          err_d[i]   = in_err_i;
          data_d[i]  = in_rdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      pc_q    <= '0;
    end else if (clear_i) begin
      valid_q <= '0;
      pc_q    <= in_addr_i[31:1];
    end else begin
      valid_q <= valid_d;
      if (handshake) pc_q <= pc_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ResetAll && rst_i) begin
      err_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      err_q <= err_d;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
    end
  end

  always_comb begin
    level_o = '0;
    for (int i = 0; i < DEPTH; i++) level_o = level_o + LVL_W'(valid_q[i]);
  end

  assign busy_o = valid_q[DEPTH-1:1];

  IbexFetchFifoPushFull: assert property (@(posedge clk_i) disable iff (rst_i)
    !(in_valid_i && valid_q[DEPTH-1] && !clear_i));

  IbexFetchFifoPushPopFull: assert property (@(posedge clk_i) disable iff (rst_i)
    !(in_valid_i && pop && valid_q[DEPTH-1] && !clear_i));

  // The upper halfword of a compressed instruction may float.
  IbexFetchFifoStable: assert property (@(posedge clk_i) disable iff (rst_i)
    (out_valid_o && !out_ready_i && !clear_i) |=> ($stable(hw0) && (is_c || $stable(hw1))));

  IbexFetchFifoStraddleSrc: assert property (@(posedge clk_i) disable iff (rst_i)
    (straddle && out_valid_o) |-> valid_q[0]);

endmodule

// File: tb/tb_ibex_fetch_fifo_wide.sv
// Directed bench for ibex_fetch_fifo_wide: a 32-bit and a 64-bit instance.
module tb_ibex_fetch_fifo_wide;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_clear, a_in_valid, a_in_err, a_ready;
  logic [31:0] a_in_addr, a_in_rdata;
  logic [1:0]  a_busy, a_level;
  logic        a_out_valid, a_out_err, a_out_err_plus2;
  logic [31:0] a_out_addr, a_out_rdata;

  logic        b_rst, b_clear, b_in_valid, b_in_err, b_ready;
  logic [31:0] b_in_addr;
  logic [63:0] b_in_rdata;
  logic [1:0]  b_busy, b_level;
  logic        b_out_valid, b_out_err, b_out_err_plus2;
  logic [31:0] b_out_addr, b_out_rdata;

  int checks = 0;
  int errors = 0;

  ibex_fetch_fifo_wide #(.NUM_REQS(2), .FETCH_W(32), .ResetAll(1'b0)) u_dut32 (
    .clk_i(clk), .rst_i(a_rst), .clear_i(a_clear), .busy_o(a_busy), .level_o(a_level),
    .in_valid_i(a_in_valid), .in_addr_i(a_in_addr), .in_rdata_i(a_in_rdata), .in_err_i(a_in_err),
    .out_valid_o(a_out_valid), .out_ready_i(a_ready), .out_addr_o(a_out_addr),
    .out_rdata_o(a_out_rdata), .out_err_o(a_out_err), .out_err_plus2_o(a_out_err_plus2)
  );

  ibex_fetch_fifo_wide #(.NUM_REQS(2), .FETCH_W(64), .ResetAll(1'b1)) u_dut64 (
    .clk_i(clk), .rst_i(b_rst), .clear_i(b_clear), .busy_o(b_busy), .level_o(b_level),
    .in_valid_i(b_in_valid), .in_addr_i(b_in_addr), .in_rdata_i(b_in_rdata), .in_err_i(b_in_err),
    .out_valid_o(b_out_valid), .out_ready_i(b_ready), .out_addr_o(b_out_addr),
    .out_rdata_o(b_out_rdata), .out_err_o(b_out_err), .out_err_plus2_o(b_out_err_plus2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1; a_clear = 0; a_in_valid = 0; a_in_err = 0; a_ready = 0; a_in_addr = 0; a_in_rdata = 0;
    b_rst = 1; b_clear = 0; b_in_valid = 0; b_in_err = 0; b_ready = 0; b_in_addr = 0; b_in_rdata = 0;
    tick();
    tick();
    a_rst = 0; b_rst = 0;
    #1;
    chk("rst_level", a_level, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_valid", a_out_valid, 0);
    chk("rst_addr", a_out_addr, 0);
    chk("rst_err", a_out_err, 0);
    chk("rst_plus2", a_out_err_plus2, 0);
    chk("rst64_level", b_level, 0);
    chk("rst64_busy", b_busy, 0);
    chk("rst64_valid", b_out_valid, 0);
    chk("rst64_addr", b_out_addr, 0);

    // 64-bit beat holding two compressed and one uncompressed instruction
    b_clear = 1; b_in_addr = 32'h100;
    tick();
    b_clear = 0;
    #1;
    chk("t1_clr_addr", b_out_addr, 32'h100);
    chk("t1_clr_valid", b_out_valid, 0);
    b_in_valid = 1; b_in_rdata = 64'h0000_0013_4501_0001; b_ready = 1;
    #1;
    chk("t1_i0_valid", b_out_valid, 1);
    chk("t1_i0_addr", b_out_addr, 32'h100);
    chk("t1_i0_hw", b_out_rdata[15:0], 16'h0001);
    tick();
    b_in_valid = 0;
    #1;
    chk("t1_i1_level", b_level, 1);
    chk("t1_i1_busy", b_busy, 2'b00);
    chk("t1_i1_addr", b_out_addr, 32'h102);
    chk("t1_i1_hw", b_out_rdata[15:0], 16'h4501);
    tick();
    chk("t1_i2_level", b_level, 1);
    chk("t1_i2_addr", b_out_addr, 32'h104);
    chk("t1_i2_rdata", b_out_rdata, 32'h0000_0013);
    chk("t1_i2_err", b_out_err, 0);
    chk("t1_i2_plus2", b_out_err_plus2, 0);
    tick();
    b_ready = 0;
    #1;
    chk("t1_done_level", b_level, 0);
    chk("t1_done_valid", b_out_valid, 0);
    chk("t1_done_addr", b_out_addr, 32'h108);

    // 32-bit straddle completed through the bypass path
    a_clear = 1; a_in_addr = 32'h202;
    tick();
    a_clear = 0; a_ready = 1; a_in_valid = 1; a_in_rdata = 32'h0093_1234;
    #1;
    chk("t2_b1_valid", a_out_valid, 0);
    chk("t2_b1_addr", a_out_addr, 32'h202);
    tick();
    a_in_rdata = 32'hABCD_0000;
    #1;
    chk("t2_b2_valid", a_out_valid, 1);
    chk("t2_b2_rdata", a_out_rdata, 32'h0000_0093);
    chk("t2_b2_addr", a_out_addr, 32'h202);
    chk("t2_b2_level", a_level, 1);
    tick();
    a_in_valid = 0;
    #1;
    chk("t2_next_level", a_level, 1);
    chk("t2_next_addr", a_out_addr, 32'h206);
    chk("t2_next_hw", a_out_rdata[15:0], 16'hABCD);
    chk("t2_next_valid", a_out_valid, 1);
    tick();
    a_ready = 0;
    #1;
    chk("t2_done_level", a_level, 0);
    chk("t2_done_addr", a_out_addr, 32'h208);

    // error only in the second halfword of a straddling instruction
    a_clear = 1; a_in_addr = 32'h302;
    tick();
    a_clear = 0; a_in_valid = 1; a_in_rdata = 32'h0003_1111; a_in_err = 0;
    #1;
    chk("t3_a_valid", a_out_valid, 0);
    tick();
    a_in_rdata = 32'h2222_3333; a_in_err = 1;
    #1;
    chk("t3_b_valid", a_out_valid, 1);
    chk("t3_b_err", a_out_err, 1);
    chk("t3_b_plus2", a_out_err_plus2, 1);
    chk("t3_b_rdata", a_out_rdata, 32'h3333_0003);
    tick();
    a_in_valid = 0; a_in_err = 0;
    #1;
    chk("t3_held_level", a_level, 2);
    chk("t3_held_busy", a_busy, 2'b01);
    chk("t3_held_err", a_out_err, 1);
    chk("t3_held_plus2", a_out_err_plus2, 1);

    // compressed at the last halfword ignores an errored next beat
    a_clear = 1; a_in_addr = 32'h30A;
    tick();
    a_clear = 0; a_in_valid = 1; a_in_rdata = 32'h0001_5555;
    #1;
    chk("t3_c_valid", a_out_valid, 1);
    chk("t3_c_level0", a_level, 0);
    tick();
    a_in_rdata = 32'h4444_0001; a_in_err = 1;
    #1;
    chk("t3_c_err", a_out_err, 0);
    chk("t3_c_plus2", a_out_err_plus2, 0);
    chk("t3_c_hw", a_out_rdata[15:0], 16'h0001);
    tick();
    a_in_valid = 0; a_in_err = 0; a_ready = 1;
    #1;
    chk("t3_c_level2", a_level, 2);
    tick();
    a_ready = 0;
    #1;
    chk("t3_d_addr", a_out_addr, 32'h30C);
    chk("t3_d_level", a_level, 1);
    chk("t3_d_err", a_out_err, 1);
    chk("t3_d_plus2", a_out_err_plus2, 0);
    a_ready = 1;
    tick();
    a_ready = 0;
    #1;
    chk("t3_d_next_addr", a_out_addr, 32'h310);
    chk("t3_d_next_level", a_level, 0);

    // fill to capacity without consuming
    a_clear = 1; a_in_addr = 32'h500;
    tick();
    a_clear = 0; a_in_valid = 1; a_in_rdata = 32'h0001_0001;
    tick();
    chk("t4_l1", a_level, 1);
    chk("t4_b1", a_busy, 2'b00);
    tick();
    chk("t4_l2", a_level, 2);
    chk("t4_b2", a_busy, 2'b01);
    tick();
    chk("t4_l3", a_level, 3);
    chk("t4_b3", a_busy, 2'b11);
    chk("t4_valid", a_out_valid, 1);

    // clear beats a simultaneous push and handshake
    a_clear = 1; a_in_addr = 32'h400; a_ready = 1; a_in_rdata = 32'h0013_0013;
    tick();
    a_clear = 0; a_in_valid = 0; a_ready = 0;
    #1;
    chk("t5_level", a_level, 0);
    chk("t5_addr", a_out_addr, 32'h400);
    chk("t5_valid", a_out_valid, 0);
    chk("t5_busy", a_busy, 2'b00);

    // PC wraps at 2^32
    a_clear = 1; a_in_addr = 32'hFFFF_FFFE;
    tick();
    a_clear = 0; a_in_valid = 1; a_in_rdata = 32'h0001_0000; a_ready = 1;
    #1;
    chk("tw_addr", a_out_addr, 32'hFFFF_FFFE);
    chk("tw_valid", a_out_valid, 1);
    tick();
    a_in_valid = 0; a_ready = 0;
    #1;
    chk("tw_next_addr", a_out_addr, 32'h0);
    chk("tw_next_level", a_level, 0);

    // reset mid-stream overrides clear and push
    a_clear = 1; a_in_addr = 32'h600;
    tick();
    a_clear = 0; a_in_valid = 1; a_in_rdata = 32'h0001_0001;
    tick();
    tick();
    a_in_valid = 0;
    #1;
    chk("t6_pre_level", a_level, 2);
    a_rst = 1; a_clear = 1; a_in_valid = 1; a_in_addr = 32'h700;
    tick();
    a_rst = 0; a_clear = 0; a_in_valid = 0;
    #1;
    chk("t6_level", a_level, 0);
    chk("t6_valid", a_out_valid, 0);
    chk("t6_addr", a_out_addr, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
